// File: rtl/sha256_msg_sequencer_if.sv
// Word-stream, compression-core and digest handshake bundle for the SHA-256 message sequencer.
// The slave view belongs to the sequencer; the master view belongs to the host/core side.
interface sha256_msg_sequencer_if;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          in_last;
   logic [1:0]    in_bytes;

   logic          core_start;
   logic          core_init;
   logic [511:0]  core_block;
   logic          core_done;
   logic [255:0]  core_digest;

   logic [255:0]  digest;
   logic          digest_valid;
   logic          digest_ready;

   modport slave (
      input  in_valid, in_data, in_last, in_bytes,
      input  core_done, core_digest,
      input  digest_ready,
      output in_ready,
      output core_start, core_init, core_block,
      output digest, digest_valid
   );

   modport master (
      output in_valid, in_data, in_last, in_bytes,
      output core_done, core_digest,
      output digest_ready,
      input  in_ready,
      input  core_start, core_init, core_block,
      input  digest, digest_valid
   );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// Packs a big-endian word stream into 512-bit blocks, applies SHA-256 padding and length,
// drives one compression per block and returns the final digest over a valid/ready handshake.
module sha256_msg_sequencer #(
   parameter int unsigned LEN_W   = 64,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                          clk,
   input  logic                          reset_n,
   sha256_msg_sequencer_if.slave         bus,
   output logic                          busy,
   output logic                          err_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_PAD,
      S_EXTRA,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_t;

   state_t              state_q;
   logic [511:0]        block_q;
   logic [255:0]        digest_q;
   logic [4:0]          widx_q;
   logic [6:0]          nbytes_q;
   logic [LEN_W-1:0]    len_q;
   logic                first_q;
   logic                final_q;
   logic                extra_80_q;
   logic                ret_extra_q;
   logic [CNT_W-1:0]    wcnt_q;
   logic                err_q;

   logic                hs;
   logic [3:0]          byte_keep;
   logic [31:0]         word_d;
   logic [2:0]          last_bytes;
   logic [5:0]          len_inc;
   logic [6:0]          nbytes_d;
   logic [63:0]         len_field;

   assign hs         = bus.in_valid && (state_q == S_FILL);
   assign last_bytes = (bus.in_last && bus.in_bytes != 2'd0) ? {1'b0, bus.in_bytes} : 3'd4;
   assign len_inc    = {last_bytes, 3'b000};
   assign nbytes_d   = {widx_q, 2'b00} + {4'd0, last_bytes};
   assign len_field  = 64'(len_q);

   // Bytes past the valid count of a partial last word are stored as zero.
   for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign byte_keep[gi] = !bus.in_last || (bus.in_bytes == 2'd0) || (2'(gi) < bus.in_bytes);
      assign word_d[31-8*gi -: 8] = byte_keep[gi] ? bus.in_data[31-8*gi -: 8] : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         block_q     <= '0;
         digest_q    <= '0;
         widx_q      <= '0;
         nbytes_q    <= '0;
         len_q       <= '0;
         first_q     <= 1'b1;
         final_q     <= 1'b0;
         extra_80_q  <= 1'b0;
         ret_extra_q <= 1'b0;
         wcnt_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  state_q <= S_FILL;
               end
            end

            S_FILL: begin
               if (hs) begin
                  block_q[{~widx_q[3:0], 5'h1f} -: 32] <= word_d;
                  widx_q <= widx_q + 5'd1;
                  len_q  <= len_q + LEN_W'(len_inc);
                  if (bus.in_last) begin
                     nbytes_q <= nbytes_d;
                     state_q  <= S_PAD;
                  end else if (widx_q == 5'd15) begin
                     final_q     <= 1'b0;
                     ret_extra_q <= 1'b0;
                     state_q     <= S_ISSUE;
                  end
               end
            end

            S_PAD: begin
               if (nbytes_q == 7'd64) begin
                  // Full block: the 0x80 marker and length spill into an extra block.
                  final_q     <= 1'b0;
                  ret_extra_q <= 1'b1;
                  extra_80_q  <= 1'b1;
               end else begin
                  block_q[9'd511 - {nbytes_q[5:0], 3'b000} -: 8] <= 8'h80;
                  if (nbytes_q <= 7'd55) begin
                     block_q[63:0] <= len_field;
                     final_q       <= 1'b1;
                  end else begin
                     final_q     <= 1'b0;
                     ret_extra_q <= 1'b1;
                     extra_80_q  <= 1'b0;
                  end
               end
               state_q <= S_ISSUE;
            end

            S_EXTRA: begin
               if (extra_80_q) begin
                  block_q[511:504] <= 8'h80;
               end
               block_q[63:0] <= len_field;
               final_q       <= 1'b1;
               state_q       <= S_ISSUE;
            end

            S_ISSUE: begin
               first_q <= 1'b0;
               wcnt_q  <= '0;
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               if (wcnt_q != CNT_W'(TIMEOUT)) begin
                  wcnt_q <= wcnt_q + CNT_W'(1);
               end
               if (TIMEOUT != 0 && wcnt_q == CNT_W'(TIMEOUT) && !bus.core_done) begin
                  err_q <= 1'b1;
               end
               if (bus.core_done) begin
                  block_q <= '0;
                  widx_q  <= '0;
                  if (final_q) begin
                     digest_q <= bus.core_digest;
                     state_q  <= S_OUT;
                  end else if (ret_extra_q) begin
                     state_q <= S_EXTRA;
                  end else begin
                     state_q <= S_FILL;
                  end
               end
            end

            S_OUT: begin
               if (bus.digest_ready) begin
                  len_q   <= '0;
                  first_q <= 1'b1;
                  widx_q  <= '0;
                  state_q <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from registered state, so they never depend on inputs.
   assign bus.in_ready     = (state_q == S_FILL);
   assign bus.core_start   = (state_q == S_ISSUE);
   assign bus.core_init    = (state_q == S_ISSUE) && first_q;
   assign bus.core_block   = block_q;
   assign bus.digest       = digest_q;
   assign bus.digest_valid = (state_q == S_OUT);
   assign busy             = (state_q != S_IDLE);
   assign err_timeout      = err_q;

endmodule
